uart_rx_operand_packer: RTL

Assembles the byte stream from the UART receiver into pairs of 32-bit floating-point operands for the FPU datapath. Sits directly downstream of the UART receiver: each received-byte strobe appends one byte; after `2*SIZE_WORD/SIZE_DATA` bytes it presents operand A and operand B on a valid/ready interface to the FPU input stage. It double-buffers so a new frame can be collected while the previous one waits for the consumer, and it discards stale partial frames on inter-byte timeout.

---
 rtl/uart_rx_operand_packer.sv | 107 ++++++++++
 1 files changed

// File: rtl/uart_rx_operand_packer.sv
// Packs UART bytes into little-endian operand pairs with a one-deep output hold register.
// Define UART_PACKER_TIMEOUT_EN to drop stale partial frames after TIMEOUT_CYCLES idle cycles.
module uart_rx_operand_packer #(
  parameter int SIZE_DATA      = 8,
  parameter int SIZE_WORD      = 32,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [SIZE_DATA-1:0] i_byte,
  input  logic                 i_byte_valid,
  input  logic                 i_flush,
  input  logic                 i_ready,
  output logic [SIZE_WORD-1:0] o_operand_a,
  output logic [SIZE_WORD-1:0] o_operand_b,
  output logic                 o_valid,
  output logic                 o_err_overrun,
  output logic                 o_err_timeout
);
  localparam int NB = 2 * SIZE_WORD / SIZE_DATA;
  localparam int AW = $clog2(NB);
  localparam int CW = AW + 1;

  if (SIZE_WORD % SIZE_DATA != 0) begin : g_bad_width
    $error("SIZE_WORD must be a multiple of SIZE_DATA");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} out_state_t;

  out_state_t             state_q;
  logic [CW-1:0]          cnt_q;
  logic [SIZE_DATA-1:0]   asm_q [NB];
  logic [2*SIZE_WORD-1:0] frame;
  logic                   last, xfer, take, drop, expire;

  // The final byte is never stored; it goes straight into the output register.
  always_comb begin
    last  = (cnt_q == CW'(NB - 1));
    xfer  = (state_q == FULL) && i_ready;
    take  = i_byte_valid && !i_flush && (!last || state_q == EMPTY || i_ready);
    drop  = i_byte_valid && !i_flush && last && state_q == FULL && !i_ready;
    frame = '0;
    for (int k = 0; k < NB; k++)
      frame[k*SIZE_DATA +: SIZE_DATA] = (k == NB - 1) ? i_byte : asm_q[k];
  end

  assign o_valid = (state_q == FULL);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q       <= EMPTY;
      cnt_q         <= '0;
      o_operand_a   <= '0;
      o_operand_b   <= '0;
      o_err_overrun <= 1'b0;
      for (int k = 0; k < NB; k++) asm_q[k] <= '0;
    end else begin
      o_err_overrun <= drop;
      if (i_flush) begin
        state_q     <= EMPTY;
        cnt_q       <= '0;
        o_operand_a <= '0;
        o_operand_b <= '0;
        for (int k = 0; k < NB; k++) asm_q[k] <= '0;
      end else if (take && last) begin
        state_q     <= FULL;
        cnt_q       <= '0;
        o_operand_a <= frame[SIZE_WORD-1:0];
        o_operand_b <= frame[2*SIZE_WORD-1:SIZE_WORD];
      end else begin
        if (xfer) state_q <= EMPTY;
        if (take) begin
          asm_q[cnt_q[AW-1:0]] <= i_byte;
          cnt_q                <= cnt_q + CW'(1);
        end else if (expire) begin
          cnt_q <= '0;
        end
      end
    end
  end

`ifdef UART_PACKER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  logic [TW-1:0] tmr_q;

  assign expire = (cnt_q != '0) && (tmr_q == TW'(TIMEOUT_CYCLES - 1));

  // A byte landing on the expiry cycle wins and restarts the gap measurement.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tmr_q         <= '0;
      o_err_timeout <= 1'b0;
    end else begin
      o_err_timeout <= expire && !i_flush && !take;
      if (i_flush || take || expire || cnt_q == '0) tmr_q <= '0;
      else                                          tmr_q <= tmr_q + TW'(1);
    end
  end
`else
  assign expire        = 1'b0;
  assign o_err_timeout = 1'b0;
`endif

endmodule
